// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide, one bit per clock, with pipeline stall and done pulse.
// Ports: clk, rst (async active-low), start_i, funct3_i, op_a_i, op_b_i,
//        flush_i | stall_o, busy_o, done_o, result_o.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg_q;
  logic              r_neg_r;
  // MUL: product {hi,lo}, lo starts as multiplier.
  // DIV: {rem,quot}, quot starts as dividend.
  logic [2*XLEN-1:0] r_acc;
  // MUL: multiplicand; DIV: divisor.
  logic [XLEN-1:0]   r_opd;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN:0]     w_msum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_rsh;
  logic [XLEN+1:0]   w_diff;
  logic              w_keep;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_fix_res;

  assign w_accept = (r_state == S_IDLE) & start_i & ~flush_i;

  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    unique case (funct3_i)
      3'b001, 3'b100, 3'b110: begin
        w_sa = op_a_i[XLEN-1];
        w_sb = op_b_i[XLEN-1];
      end
      3'b010:  w_sa = op_a_i[XLEN-1];
      default: ;
    endcase
  end

  assign w_mag_a  = w_sa ? -op_a_i : op_a_i;
  assign w_mag_b  = w_sb ? -op_b_i : op_b_i;
  assign w_b_zero = (op_b_i == '0);
  assign w_ovf    = funct3_i[2] & ~funct3_i[0]
                  & (op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                  & (&op_b_i);
  assign w_special = funct3_i[2] & (w_b_zero | w_ovf);

  always_comb begin
    w_spec_res = '0;
    if (w_b_zero)
      w_spec_res = funct3_i[1] ? op_a_i : '1;
    else
      w_spec_res = funct3_i[1] ? '0 : op_a_i;
  end

  assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                + {1'b0, (r_acc[0] ? r_opd : {XLEN{1'b0}})};
  assign w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};

  // Remainder after shift can be XLEN+1 bits wide.
  assign w_rsh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff = {1'b0, w_rsh} - {2'b00, r_opd};
  assign w_keep = ~w_diff[XLEN+1];
  assign w_div_nxt = {(w_keep ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0]),
                      r_acc[XLEN-2:0], w_keep};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_q    = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_r    = r_neg_r ? -r_acc[2*XLEN-1:XLEN]
                          : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    if (r_f3[2])
      w_fix_res = r_f3[1] ? w_r : w_q;
    else if (r_f3[1:0] == 2'b00)
      w_fix_res = w_prod[XLEN-1:0];
    else
      w_fix_res = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_opd    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3    <= funct3_i;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= CW'(XLEN-1);
            if (funct3_i[2]) begin
              r_acc <= {{XLEN{1'b0}}, w_mag_a};
              r_opd <= w_mag_b;
            end else begin
              r_acc <= {{XLEN{1'b0}}, w_mag_b};
              r_opd <= w_mag_a;
            end
            if (w_special) begin
              r_result <= w_spec_res;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= r_f3[2] ? w_div_nxt : w_mul_nxt;
            if (r_cnt == '0)
              r_state <= S_FIX;
            else
              r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix_res;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o  = w_accept | (r_state == S_CALC) | (r_state == S_FIX);
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE) & ~flush_i;
  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer.
// Cycle 0 is the accept cycle; samples taken just after the falling edge.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output int cyc,
                       output logic [31:0] res, output logic [63:0] smask);
    @(negedge clk);
    start_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b;
    #1;
    cyc = -1; res = '0; smask = '0;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start_i = 1'b0;
        #1;
      end
      smask[c] = stall_o;
      if (done_o) begin
        cyc = c;
        res = result_o;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; op_a_i = '0; op_b_i = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks += 4;
    if (result_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 0", result_o);
    end
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o);
    end
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", done_o);
    end
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mul;
    int c; logic [31:0] r; logic [63:0] m;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, c, r, m);
    n_checks += 3;
    if (r !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL mul_result: got %h expected ffffffeb", r);
    end
    if (c !== 34) begin
      n_fail++; $display("FAIL mul_latency: got %0d expected 34", c);
    end
    if (m !== 64'h3_FFFF_FFFF) begin
      n_fail++; $display("FAIL mul_stall: got %h expected 3ffffffff", m);
    end
  endtask

  task automatic test_mulh;
    logic [2:0]  f3 [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] a  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] e  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int c; logic [31:0] r; logic [63:0] m;
    for (int i = 0; i < 3; i++) begin
      do_op(f3[i], a[i], b[i], c, r, m);
      n_checks += 2;
      if (r !== e[i]) begin
        n_fail++;
        $display("FAIL mulh_result[%0d]: got %h expected %h", i, r, e[i]);
      end
      if (c !== 34) begin
        n_fail++;
        $display("FAIL mulh_latency[%0d]: got %0d expected 34", i, c);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] e  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int c; logic [31:0] r; logic [63:0] m;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], c, r, m);
      n_checks += 2;
      if (r !== e[i]) begin
        n_fail++;
        $display("FAIL div_result[%0d]: got %h expected %h", i, r, e[i]);
      end
      if (c !== 34) begin
        n_fail++;
        $display("FAIL div_latency[%0d]: got %0d expected 34", i, c);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] a  [4] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e  [4] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0};
    int c; logic [31:0] r; logic [63:0] m;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], c, r, m);
      n_checks += 2;
      if (r !== e[i]) begin
        n_fail++;
        $display("FAIL special_result[%0d]: got %h expected %h", i, r, e[i]);
      end
      if (c !== 1) begin
        n_fail++;
        $display("FAIL special_latency[%0d]: got %0d expected 1", i, c);
      end
    end
  endtask

  task automatic test_flush;
    int c; logic [31:0] r; logic [63:0] m;
    logic seen; logic busy11;
    do_op(3'b101, 32'd100, 32'd7, c, r, m);
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b100; op_a_i = 32'd1000; op_b_i = 32'd7;
    #1;
    seen = 1'b0; busy11 = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(negedge clk);
        start_i = 1'b0;
        flush_i = (k == 10);
        #1;
      end
      if (done_o) seen = 1'b1;
      if (k == 11) busy11 = busy_o;
    end
    flush_i = 1'b0;
    n_checks += 3;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL flush_done: got %b expected 0", seen);
    end
    if (busy11 !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got busy %b expected 0", busy11);
    end
    if (result_o !== 32'd14) begin
      n_fail++; $display("FAIL flush_result: got %h expected e", result_o);
    end
  endtask

  task automatic test_busy_start;
    int cyc; logic [31:0] r;
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd7; op_b_i = 32'd9;
    #1;
    cyc = -1; r = '0;
    for (int k = 0; k < 50; k++) begin
      if (k > 0) begin
        @(negedge clk);
        start_i = (k == 5);
        if (k == 5) begin
          funct3_i = 3'b100; op_a_i = 32'd1000; op_b_i = 32'd3;
        end
        #1;
      end
      if (done_o) begin
        cyc = k; r = result_o;
        break;
      end
    end
    start_i = 1'b0;
    n_checks += 2;
    if (r !== 32'd63) begin
      n_fail++; $display("FAIL busy_start_result: got %h expected 3f", r);
    end
    if (cyc !== 34) begin
      n_fail++; $display("FAIL busy_start_latency: got %0d expected 34", cyc);
    end
  endtask

  task automatic test_reset_mid;
    int c; logic [31:0] r; logic [63:0] m;
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'h1234; op_b_i = 32'h10;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b0;
    #1;
    n_checks += 4;
    if (result_o !== 32'h0) begin
      n_fail++; $display("FAIL midrst_result: got %h expected 0", result_o);
    end
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_o);
    end
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_done: got %b expected 0", done_o);
    end
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_stall: got %b expected 0", stall_o);
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(3'b000, 32'd3, 32'd5, c, r, m);
    n_checks += 2;
    if (r !== 32'd15) begin
      n_fail++; $display("FAIL midrst_mul_result: got %h expected f", r);
    end
    if (c !== 34) begin
      n_fail++; $display("FAIL midrst_mul_latency: got %0d expected 34", c);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_busy_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
